i2s_capture_ctrl: RTL and testbench
===================================

Name: i2s_capture_ctrl

Overview:
- Sequencer for the I2S MEMS-mic capture path.
- Generates the bit clock (i2s_clk) and word select (lrcl_clk) from audio_clk.
- Tracks the 64-bit stereo frame and samples mic_data on the correct bit slots.
- Hands each completed left/right sample pair to downstream DSP over a valid/ready interface, with overflow detection and clean start/stop on frame boundaries.

Parameters:
- CLK_DIV, 4: audio_clk cycles per half i2s_clk period (>=2).
- SAMPLE_BITS, 24: sample bits captured per channel, MSB first (<=31).

Ports:
- audio_clk  input  1  sole clock.
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  level; high = capture, low = stop at end of current frame.
- mic_data  input  1  serial data from mic.
- i2s_clk  output  1  bit clock to mic.
- lrcl_clk  output  1  word select; 0 = left slot, 1 = right slot.
- sample_valid_out  output  1  left_out/right_out hold an unconsumed frame.
- sample_ready_in  input  1  downstream accepts.
- left_out  output  SAMPLE_BITS  left sample.
- right_out  output  SAMPLE_BITS  right sample.
- overflow_out  output  1  sticky: a completed frame was dropped.
- ovf_clr_in  input  1  one-cycle pulse clears overflow_out.

Behaviour:
- Reset (rst_in=0, async): state IDLE; i2s_clk, lrcl_clk, sample_valid_out and overflow_out are 0; left_out and right_out are 0; div_cnt=0; bit_idx=0; shift registers 0.
- States: IDLE, RUN, STOP.
  - IDLE: clocks held low. enable_in=1 -> RUN at next edge, with div_cnt=0, bit_idx=0, i2s_clk=0, lrcl_clk=0.
  - RUN: enable_in=0 -> STOP.
  - STOP: clocking continues. enable_in=1 -> RUN (stop cancelled). At the frame-end event -> IDLE: i2s_clk and lrcl_clk forced 0, and the final frame is still delivered.
- Divider:
  - div_cnt increments every cycle in RUN/STOP.
  - At CLK_DIV-1, div_cnt wraps to 0 and i2s_clk toggles.
  - First rising edge occurs CLK_DIV cycles after RUN entry.
  - Frame = 64 bit periods = 128*CLK_DIV cycles (512 at default).
- Events, each a single-cycle internal strobe on the toggle cycle:
  - rise_ev: i2s_clk is 0 and about to go to 1.
  - fall_ev: i2s_clk is 1 and about to go to 0.
- bit_idx 0..63:
  - Increments on fall_ev and wraps 63 -> 0.
  - lrcl_clk is registered as (next bit_idx >= 32), so it changes only on falling edges.
- Capture (I2S one-bit delay, MSB first):
  - On rise_ev with bit_idx in 1..SAMPLE_BITS: shift mic_data into left_sr.
  - On rise_ev with bit_idx in 33..32+SAMPLE_BITS: shift mic_data into right_sr.
  - All other bits are ignored.
- Frame end = fall_ev with bit_idx==63.
  - If sample_valid_out=0, or a transfer occurs in the same cycle (valid & ready): load left_out/right_out from the shift registers and set sample_valid_out=1 next cycle.
  - Otherwise: drop the new frame, retain the held frame, and set overflow_out.
- Handshake:
  - Transfer occurs on a cycle with sample_valid_out & sample_ready_in.
  - After a transfer, valid drops next cycle unless a frame end coincides, in which case valid stays 1 with new data and no overflow.
  - Data is stable while valid=1 and not transferred.
- Overflow:
  - Sticky; cleared by ovf_clr_in.
  - Simultaneous set and clear: set wins.
- enable_in deasserted during IDLE has no effect; sample_valid_out/left_out/right_out persist in IDLE until consumed.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-RUN: assert rst_in=0 at arbitrary cycle -> all outputs 0 immediately (async), state IDLE; release -> i2s_clk stays 0 until enable_in=1.
- Timing: enable_in=1, CLK_DIV=4 -> i2s_clk period 8 cycles. lrcl_clk rises on the 32nd falling i2s_clk edge and falls on the 64th. First sample_valid_out is 1 the cycle after the 64th falling edge (512 cycles after RUN entry).
- Data: bench drives bit-accurate I2S with left=0xA5A5A5, right=0x5A5A5A (bits 25..31 random), sample_ready_in=1 -> left_out=0xA5A5A5, right_out=0x5A5A5A each frame; mic_data held 1 -> 0xFFFFFF/0xFFFFFF.
- Backpressure: sample_ready_in=0 for 2 frames -> first frame held unchanged and overflow_out=1 after the second frame end. ovf_clr_in pulse -> 0. Ready raised exactly on a frame-end cycle -> new frame loaded, valid stays 1, no overflow.
- Stop: drop enable_in at bit_idx=10 -> frame completes, one final valid frame, then i2s_clk/lrcl_clk low. Re-raise enable_in in STOP -> capture continues without gap.

Source files
------------

// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl
// Capture sequencer for an I2S MEMS microphone. It divides audio_clk down to
// the bit clock, generates word select, samples mic_data in the left and
// right slots of each 64-bit frame, and hands each finished stereo pair to
// downstream logic over a valid/ready interface.
//
// Ports:
//   audio_clk        in   sole clock
//   rst_in           in   asynchronous active-low reset
//   enable_in        in   1 = capture, 0 = stop at the end of the current frame
//   mic_data         in   serial data from the microphone
//   i2s_clk          out  bit clock to the microphone
//   lrcl_clk         out  word select (0 = left slot, 1 = right slot)
//   sample_valid_out out  left_out/right_out hold an unconsumed frame
//   sample_ready_in  in   downstream accepts the held frame
//   left_out         out  left sample, SAMPLE_BITS wide
//   right_out        out  right sample, SAMPLE_BITS wide
//   overflow_out     out  sticky flag: a completed frame was dropped
//   ovf_clr_in       in   one-cycle pulse that clears overflow_out
module i2s_capture_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 24
) (
  input  logic                   audio_clk,
  input  logic                   rst_in,
  input  logic                   enable_in,
  input  logic                   mic_data,
  output logic                   i2s_clk,
  output logic                   lrcl_clk,
  output logic                   sample_valid_out,
  input  logic                   sample_ready_in,
  output logic [SAMPLE_BITS-1:0] left_out,
  output logic [SAMPLE_BITS-1:0] right_out,
  output logic                   overflow_out,
  input  logic                   ovf_clr_in
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] LEFT_LAST  = 6'(SAMPLE_BITS);
  localparam logic [5:0] RIGHT_LAST = 6'(32 + SAMPLE_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                 state_r;
  logic [DIV_W-1:0]       div_cnt_r;
  logic [5:0]             bit_idx_r;
  logic [SAMPLE_BITS-1:0] left_sr_r;
  logic [SAMPLE_BITS-1:0] right_sr_r;

  logic       active_s;
  logic       toggle_s;
  logic       rise_ev_s;
  logic       fall_ev_s;
  logic       frame_end_s;
  logic       xfer_s;
  logic       left_win_s;
  logic       right_win_s;
  logic [5:0] bit_next_s;

  assign active_s    = (state_r != IDLE);
  assign toggle_s    = active_s && (div_cnt_r == DIV_LAST);
  assign rise_ev_s   = toggle_s && !i2s_clk;
  assign fall_ev_s   = toggle_s && i2s_clk;
  assign bit_next_s  = bit_idx_r + 6'd1;  // natural 6-bit wrap 63 -> 0
  assign frame_end_s = fall_ev_s && (bit_idx_r == 6'd63);
  assign xfer_s      = sample_valid_out && sample_ready_in;
  // One-bit I2S delay: the MSB of each channel sits in slot 1 / slot 33.
  assign left_win_s  = (bit_idx_r >= 6'd1)  && (bit_idx_r <= LEFT_LAST);
  assign right_win_s = (bit_idx_r >= 6'd33) && (bit_idx_r <= RIGHT_LAST);

  // Sequencer: state, clock divider, bit clock, bit counter and word select.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      bit_idx_r <= 6'd0;
      i2s_clk   <= 1'b0;
      lrcl_clk  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          div_cnt_r <= '0;
          bit_idx_r <= 6'd0;
          i2s_clk   <= 1'b0;
          lrcl_clk  <= 1'b0;
          state_r   <= enable_in ? RUN : IDLE;
        end
        RUN, STOP: begin
          if ((state_r == STOP) && !enable_in && frame_end_s) begin
            // Last frame finished: park both clocks low.
            state_r   <= IDLE;
            div_cnt_r <= '0;
            bit_idx_r <= 6'd0;
            i2s_clk   <= 1'b0;
            lrcl_clk  <= 1'b0;
          end else begin
            state_r   <= enable_in ? RUN : STOP;
            div_cnt_r <= toggle_s ? '0 : (div_cnt_r + DIV_W'(1));
            if (toggle_s) begin
              i2s_clk <= !i2s_clk;
            end
            // Word select only moves on falling bit-clock edges.
            if (fall_ev_s) begin
              bit_idx_r <= bit_next_s;
              lrcl_clk  <= (bit_next_s >= 6'd32);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= '0;
          bit_idx_r <= 6'd0;
          i2s_clk   <= 1'b0;
          lrcl_clk  <= 1'b0;
        end
      endcase
    end
  end

  // Serial capture: shift mic_data in MSB first on rising bit-clock edges.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      left_sr_r  <= '0;
      right_sr_r <= '0;
    end else if (rise_ev_s) begin
      if (left_win_s) begin
        left_sr_r <= {left_sr_r[SAMPLE_BITS-2:0], mic_data};
      end
      if (right_win_s) begin
        right_sr_r <= {right_sr_r[SAMPLE_BITS-2:0], mic_data};
      end
    end
  end

  // Output holding register, valid/ready handshake and sticky overflow.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      sample_valid_out <= 1'b0;
      left_out         <= '0;
      right_out        <= '0;
      overflow_out     <= 1'b0;
    end else begin
      if (frame_end_s && (!sample_valid_out || xfer_s)) begin
        left_out         <= left_sr_r;
        right_out        <= right_sr_r;
        sample_valid_out <= 1'b1;
      end else if (xfer_s) begin
        sample_valid_out <= 1'b0;
      end
      // A drop in the same cycle as a clear request keeps the flag set.
      if (frame_end_s && sample_valid_out && !xfer_s) begin
        overflow_out <= 1'b1;
      end else if (ovf_clr_in) begin
        overflow_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
module tb_i2s_capture_ctrl;

  localparam int CLK_DIV = 4;
  localparam int SB      = 24;

  logic          audio_clk = 1'b0;
  logic          rst_in = 1'b0;
  logic          enable_in = 1'b0;
  logic          mic_data = 1'b0;
  logic          sample_ready_in = 1'b0;
  logic          ovf_clr_in = 1'b0;
  logic          i2s_clk;
  logic          lrcl_clk;
  logic          sample_valid_out;
  logic          overflow_out;
  logic [SB-1:0] left_out;
  logic [SB-1:0] right_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mic_slot = 0;
  logic [SB-1:0] cur_l = '0;
  logic [SB-1:0] cur_r = '0;
  bit mic_ones = 1'b0;

  i2s_capture_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_BITS(SB)) dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .mic_data        (mic_data),
    .i2s_clk         (i2s_clk),
    .lrcl_clk        (lrcl_clk),
    .sample_valid_out(sample_valid_out),
    .sample_ready_in (sample_ready_in),
    .left_out        (left_out),
    .right_out       (right_out),
    .overflow_out    (overflow_out),
    .ovf_clr_in      (ovf_clr_in)
  );

  always #5 audio_clk = ~audio_clk;

  // Microphone model: present the bit for the new slot after each falling edge.
  always @(negedge i2s_clk) begin
    mic_slot = (mic_slot == 63) ? 0 : mic_slot + 1;
    if (mic_ones)
      mic_data = 1'b1;
    else if (mic_slot >= 1 && mic_slot <= SB)
      mic_data = cur_l[SB - mic_slot];
    else if (mic_slot >= 33 && mic_slot <= 32 + SB)
      mic_data = cur_r[32 + SB - mic_slot];
    else
      mic_data = 1'($urandom_range(1, 0));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge audio_clk);
      cyc++;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic start_run(input logic [SB-1:0] l, input logic [SB-1:0] r);
    cur_l = l;
    cur_r = r;
    mic_ones = 1'b0;
    mic_slot = 0;
    enable_in = 1'b1;
    @(negedge audio_clk);
    cyc = 0;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    enable_in = 1'b0;
    repeat (3) @(negedge audio_clk);
    tests++;
    if ({i2s_clk, lrcl_clk, sample_valid_out, overflow_out, left_out, right_out} !== '0) begin
      fails++;
      $display("FAIL reset_state: got clk=%b lr=%b v=%b ovf=%b l=%h r=%h, expected all 0",
               i2s_clk, lrcl_clk, sample_valid_out, overflow_out, left_out, right_out);
    end
    rst_in = 1'b1;
    repeat (20) @(negedge audio_clk);
    tests++;
    if ({i2s_clk, lrcl_clk} !== 2'b00) begin
      fails++;
      $display("FAIL idle_clocks: got %b%b expected 00", i2s_clk, lrcl_clk);
    end
  endtask

  task automatic test_timing;
    int err_clk = 0;
    int err_lr = 0;
    int err_v = 0;
    sample_ready_in = 1'b1;
    start_run(24'hA5A5A5, 24'h5A5A5A);
    for (int c = 0; c < 512; c++) begin
      if (i2s_clk !== (((c >> 2) % 2) == 1)) err_clk++;
      if (lrcl_clk !== (((c >> 8) % 2) == 1)) err_lr++;
      if (sample_valid_out !== 1'b0) err_v++;
      tick(1);
    end
    tests++;
    if (err_clk != 0) begin fails++; $display("FAIL i2s_clk_period: %0d bad cycles, expected 0", err_clk); end
    tests++;
    if (err_lr != 0) begin fails++; $display("FAIL lrcl_timing: %0d bad cycles, expected 0", err_lr); end
    tests++;
    if (err_v != 0) begin fails++; $display("FAIL early_valid: %0d bad cycles, expected 0", err_v); end
    tests++;
    if ({sample_valid_out, left_out, right_out, lrcl_clk} !== {1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0}) begin
      fails++;
      $display("FAIL first_frame: got v=%b l=%h r=%h lr=%b expected v=1 l=a5a5a5 r=5a5a5a lr=0",
               sample_valid_out, left_out, right_out, lrcl_clk);
    end
  endtask

  task automatic test_data;
    cur_l = 24'h123456;
    cur_r = 24'hFEDCBA;
    goto(513);
    tests++;
    if (sample_valid_out !== 1'b0) begin fails++; $display("FAIL valid_drop: got %b expected 0", sample_valid_out); end
    goto(1024);
    tests++;
    if ({sample_valid_out, left_out, right_out} !== {1'b1, 24'h123456, 24'hFEDCBA}) begin
      fails++;
      $display("FAIL data_pattern: got v=%b l=%h r=%h expected v=1 l=123456 r=fedcba",
               sample_valid_out, left_out, right_out);
    end
    mic_ones = 1'b1;
    goto(1536);
    tests++;
    if ({sample_valid_out, left_out, right_out} !== {1'b1, 24'hFFFFFF, 24'hFFFFFF}) begin
      fails++;
      $display("FAIL data_ones: got v=%b l=%h r=%h expected v=1 l=ffffff r=ffffff",
               sample_valid_out, left_out, right_out);
    end
  endtask

  task automatic test_backpressure;
    mic_ones = 1'b0;
    cur_l = 24'h0F0F0F;
    cur_r = 24'hF0F0F0;
    goto(1537);
    sample_ready_in = 1'b0;
    goto(2048);
    tests++;
    if ({sample_valid_out, left_out, right_out, overflow_out} !== {1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b0}) begin
      fails++;
      $display("FAIL bp_first: got v=%b l=%h r=%h ovf=%b expected v=1 l=0f0f0f r=f0f0f0 ovf=0",
               sample_valid_out, left_out, right_out, overflow_out);
    end
    cur_l = 24'h111111;
    cur_r = 24'h222222;
    goto(2560);
    tests++;
    if ({sample_valid_out, left_out, right_out, overflow_out} !== {1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b1}) begin
      fails++;
      $display("FAIL bp_overflow: got v=%b l=%h r=%h ovf=%b expected v=1 l=0f0f0f r=f0f0f0 ovf=1",
               sample_valid_out, left_out, right_out, overflow_out);
    end
    cur_l = 24'h333333;
    cur_r = 24'h444444;
    ovf_clr_in = 1'b1;
    tick(1);
    ovf_clr_in = 1'b0;
    tests++;
    if (overflow_out !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", overflow_out); end
    goto(3071);
    sample_ready_in = 1'b1;
    tick(1);
    sample_ready_in = 1'b0;
    tests++;
    if ({sample_valid_out, left_out, right_out, overflow_out} !== {1'b1, 24'h333333, 24'h444444, 1'b0}) begin
      fails++;
      $display("FAIL ready_at_frame_end: got v=%b l=%h r=%h ovf=%b expected v=1 l=333333 r=444444 ovf=0",
               sample_valid_out, left_out, right_out, overflow_out);
    end
    cur_l = 24'h555555;
    cur_r = 24'h666666;
    goto(3583);
    ovf_clr_in = 1'b1;
    tick(1);
    tests++;
    if ({overflow_out, left_out} !== {1'b1, 24'h333333}) begin
      fails++;
      $display("FAIL ovf_set_wins: got ovf=%b l=%h expected ovf=1 l=333333", overflow_out, left_out);
    end
    tick(1);
    ovf_clr_in = 1'b0;
    tests++;
    if (overflow_out !== 1'b0) begin fails++; $display("FAIL ovf_clear2: got %b expected 0", overflow_out); end
    sample_ready_in = 1'b1;
    tick(1);
    tests++;
    if (sample_valid_out !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", sample_valid_out); end
  endtask

  task automatic test_stop;
    int err_idle = 0;
    goto(4096);
    cur_l = 24'h777777;
    cur_r = 24'h888888;
    goto(4176);
    enable_in = 1'b0;
    goto(4204);
    tests++;
    if (i2s_clk !== 1'b1) begin fails++; $display("FAIL stop_still_clocking: got %b expected 1", i2s_clk); end
    goto(4608);
    tests++;
    if ({sample_valid_out, left_out, right_out, i2s_clk, lrcl_clk} !== {1'b1, 24'h777777, 24'h888888, 2'b00}) begin
      fails++;
      $display("FAIL stop_final_frame: got v=%b l=%h r=%h clk=%b lr=%b expected v=1 l=777777 r=888888 clk=0 lr=0",
               sample_valid_out, left_out, right_out, i2s_clk, lrcl_clk);
    end
    tick(1);
    tests++;
    if (sample_valid_out !== 1'b0) begin fails++; $display("FAIL stop_drain: got %b expected 0", sample_valid_out); end
    for (int c = 0; c < 32; c++) begin
      if ({i2s_clk, lrcl_clk} !== 2'b00) err_idle++;
      tick(1);
    end
    tests++;
    if (err_idle != 0) begin fails++; $display("FAIL stop_clocks_low: %0d bad cycles, expected 0", err_idle); end
  endtask

  task automatic test_restart_in_stop;
    start_run(24'h9ABCDE, 24'h13579B);
    goto(100);
    enable_in = 1'b0;
    goto(200);
    enable_in = 1'b1;
    goto(512);
    tests++;
    if ({sample_valid_out, left_out, right_out} !== {1'b1, 24'h9ABCDE, 24'h13579B}) begin
      fails++;
      $display("FAIL restart_frame0: got v=%b l=%h r=%h expected v=1 l=9abcde r=13579b",
               sample_valid_out, left_out, right_out);
    end
    cur_l = 24'h2468AC;
    cur_r = 24'hFDB975;
    goto(600);
    enable_in = 1'b0;
    goto(700);
    enable_in = 1'b1;
    goto(1024);
    tests++;
    if ({sample_valid_out, left_out, right_out} !== {1'b1, 24'h2468AC, 24'hFDB975}) begin
      fails++;
      $display("FAIL restart_frame1: got v=%b l=%h r=%h expected v=1 l=2468ac r=fdb975",
               sample_valid_out, left_out, right_out);
    end
    goto(1028);
    tests++;
    if (i2s_clk !== 1'b1) begin fails++; $display("FAIL restart_no_gap: got %b expected 1", i2s_clk); end
  endtask

  task automatic test_reset_mid_run;
    sample_ready_in = 1'b0;
    goto(2048);
    tests++;
    if ({sample_valid_out, overflow_out} !== 2'b11) begin
      fails++;
      $display("FAIL pre_reset_state: got v=%b ovf=%b expected 11", sample_valid_out, overflow_out);
    end
    goto(2100);
    #2;
    rst_in = 1'b0;
    #1;
    tests++;
    if ({i2s_clk, lrcl_clk, sample_valid_out, overflow_out, left_out, right_out} !== '0) begin
      fails++;
      $display("FAIL async_reset: got clk=%b lr=%b v=%b ovf=%b l=%h r=%h expected all 0",
               i2s_clk, lrcl_clk, sample_valid_out, overflow_out, left_out, right_out);
    end
    enable_in = 1'b0;
    @(negedge audio_clk);
    rst_in = 1'b1;
    repeat (30) @(negedge audio_clk);
    tests++;
    if (i2s_clk !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got %b expected 0", i2s_clk); end
    sample_ready_in = 1'b1;
    start_run(24'h000000, 24'h000000);
    goto(4);
    tests++;
    if (i2s_clk !== 1'b1) begin fails++; $display("FAIL post_reset_run: got %b expected 1", i2s_clk); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_data();
    test_backpressure();
    test_stop();
    test_restart_in_stop();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
